inst_queue: RTL and testbench
=============================

# inst_queue

Two-wide instruction queue between fetch and decode. Each fetch packet carries two slots, each with its own valid bit. Slot 0 is invalid when a fetch starts at a PC with bit 2 set; a packet may also arrive with only slot 0 valid. The queue compacts the valid slots in program order, buffers them in a circular store, and presents up to two oldest instructions to decode per cycle. It sits downstream of the IF stages and upstream of the decoder, and is cleared on redirect.

## Interface
Parameters:
- `DEPTH`, default 8: entry count; must be a power of two and at least 4.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: redirect; discards all contents.
- `in_valid` input 1: a fetch packet is presented.
- `in_ready` output 1: the queue can accept a full packet (free entries ≥ 2).
- `in_inst0_valid` / `in_inst1_valid` input 1 each: per-slot valid.
- `in_inst0_pc` / `in_inst1_pc` input 32 each: slot PC.
- `in_inst0_inst` / `in_inst1_inst` input 32 each: slot instruction word.
- `out0_valid` / `out1_valid` output 1 each: the head entry and head+1 entry are presented.
- `out0_pc`, `out0_inst`, `out1_pc`, `out1_inst` output 32 each: presented entries.
- `dec_ready` input 1: decode consumes every presented valid entry this cycle.

## Operation
- Storage is `DEPTH` entries of {pc, inst}.
- Pointers `head` and `tail` are `$clog2(DEPTH)` bits wide and wrap naturally modulo `DEPTH`.
- `count` is `$clog2(DEPTH)+1` bits wide.
- Enqueue fires on `in_valid & in_ready & ~flush`.
  - `n_in` = `in_inst0_valid` + `in_inst1_valid`, in the range 0–2.
  - Valid slots are written in slot order starting at `tail`.
  - If only slot 1 is valid, it is written to `tail`.
  - `tail` advances by `n_in`.
  - `n_in` = 0 is legal and is a no-op.
- `in_ready` = (`DEPTH` − `count`) ≥ 2. It depends only on registered state and never on `dec_ready`.
- Output presentation:
  - `out0_valid` = `count` ≥ 1.
  - `out1_valid` = `count` ≥ 2.
  - Data for the two outputs is read from `head` and `head+1` (mod `DEPTH`).
  - When an output is invalid, its data is don't-care.
- Dequeue:
  - `n_out` = `out0_valid` + `out1_valid` when `dec_ready`, else 0.
  - `head` advances by `n_out`.
- Count update: `count` ← `count` + `n_in` − `n_out`. Simultaneous enqueue and dequeue are always legal, including on the wrap boundary.
- Flush takes priority over everything else. On the cycle after `flush`:
  - `head`, `tail` and `count` are 0.
  - Any enqueue and dequeue in the flush cycle are discarded.
  - Entries presented during the flush cycle are still visible that cycle. Decode is responsible for killing them.
- Reset behaves identically to flush and overrides it.
- Reset values:
  - `count`, `head`, `tail` = 0.
  - `out0_valid` = `out1_valid` = 0.
  - `in_ready` = 1.
  - Storage contents are not reset.

## Timing
- Without bypass, an entry enqueued in cycle N is presentable in cycle N+1.
- Dequeue takes effect at the clock edge. The next entries are presented in the following cycle.
- `in_ready` is computed from registers only. There is no combinational path from `dec_ready` or `in_*` to `in_ready`.
- Full boundary: at `count` = `DEPTH`−1, `in_ready` = 0 even if the packet has only one valid slot.
- Empty boundary: at `count` = 0, no dequeue occurs regardless of `dec_ready`.

## Configuration
- `INST_QUEUE_BYPASS_EN` defined, when `count` = 0 and no flush:
  - The input slots appear combinationally on `out0`/`out1` in compacted order.
  - If `dec_ready` is also high, the bypassed slots are not written and the pointers do not change.
  - If `dec_ready` is low, the slots are enqueued normally.
  - This creates a combinational path from `in_*` to `out*`.
- Macro undefined: no bypass path; latency is as stated under Timing.

## Structure
- Shared package `inst_queue_pkg` contains:
  - typedef `iq_entry_t` {pc[31:0], inst[31:0]}.
  - constant `IQ_DEFAULT_DEPTH` = 8.
- Sub-module `inst_queue_compact` (purely combinational):
  - Maps the two input slots plus their valid bits to two compacted slots and `n_in`.
  - Reused by the bypass path.

## Test plan
- Reset, then idle → `out0_valid` = `out1_valid` = 0, `in_ready` = 1, `count` = 0.
- Enqueue {slot0 invalid, slot1 pc 0x1004}, then {0x1008, 0x100C}, with `dec_ready` = 0 → after 2 cycles `count` = 3; `out0_pc` = 0x1004, `out1_pc` = 0x1008.
- Fill with `DEPTH`=8 and `dec_ready` = 0 → `in_ready` drops at `count` = 7. With 4 full packets, `count` = 8 and `in_ready` = 0.
- Sustained enqueue of 2 and dequeue of 2 across more than 3×`DEPTH` packets → program-order PCs preserved across pointer wrap; `count` stays constant.
- `flush` with `count` = 5, simultaneous with a valid packet and `dec_ready` = 1 → next cycle `count` = 0, both output valids 0, the packet is dropped.
- With bypass: empty queue, packet {0x2000, 0x2004}, `dec_ready` = 1 → same-cycle `out0_pc` = 0x2000, `out1_pc` = 0x2004, and `count` stays 0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the two-wide fetch-to-decode instruction queue.
package inst_queue_pkg;

   localparam int unsigned IQ_DEFAULT_DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

endpackage

// File: rtl/inst_queue_compact.sv
// Packs the valid fetch slots into program order and counts them; purely combinational.
module inst_queue_compact
   import inst_queue_pkg::*;
(
   input  logic      slot0_valid,
   input  logic      slot1_valid,
   input  iq_entry_t slot0,
   input  iq_entry_t slot1,
   output iq_entry_t cmp0,
   output iq_entry_t cmp1,
   output logic [1:0] n_valid
);

   always_comb begin
      // A lone slot 1 moves down so the oldest valid instruction is always cmp0.
      cmp0    = slot0_valid ? slot0 : slot1;
      cmp1    = slot1;
      n_valid = {1'b0, slot0_valid} + {1'b0, slot1_valid};
   end

endmodule

// File: rtl/inst_queue.sv
// Two-wide circular instruction queue between fetch and decode.
// Optional same-cycle bypass when empty: define INST_QUEUE_BYPASS_EN.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEFAULT_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_inst0_valid,
   input  logic        in_inst1_valid,
   input  logic [31:0] in_inst0_pc,
   input  logic [31:0] in_inst1_pc,
   input  logic [31:0] in_inst0_inst,
   input  logic [31:0] in_inst1_inst,
   output logic        out0_valid,
   output logic        out1_valid,
   output logic [31:0] out0_pc,
   output logic [31:0] out0_inst,
   output logic [31:0] out1_pc,
   output logic [31:0] out1_inst,
   input  logic        dec_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   iq_entry_t mem_q [DEPTH];
   ptr_t      head_q, head_d, tail_q, tail_d;
   cnt_t      count_q, count_d;

   iq_entry_t slot0, slot1, cmp0, cmp1, rd0, rd1;
   logic [1:0] n_in, n_out;
   logic       q_v0, q_v1, enq, byp_take;

   assign slot0 = {in_inst0_pc, in_inst0_inst};
   assign slot1 = {in_inst1_pc, in_inst1_inst};

   inst_queue_compact u_compact (
      .slot0_valid (in_inst0_valid),
      .slot1_valid (in_inst1_valid),
      .slot0       (slot0),
      .slot1       (slot1),
      .cmp0        (cmp0),
      .cmp1        (cmp1),
      .n_valid     (n_in)
   );

   assign rd0      = mem_q[head_q];
   assign rd1      = mem_q[head_q + ptr_t'(1)];
   assign q_v0     = (count_q != '0);
   assign q_v1     = (count_q >= cnt_t'(2));
   // Registered-only: never depends on dec_ready or the incoming packet.
   assign in_ready = (count_q <= cnt_t'(DEPTH - 2));

   always_comb begin
      out0_valid = q_v0;
      out1_valid = q_v1;
      out0_pc    = rd0.pc;
      out0_inst  = rd0.inst;
      out1_pc    = rd1.pc;
      out1_inst  = rd1.inst;
      byp_take   = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      if ((count_q == '0) && !flush && in_valid) begin
         out0_valid = (n_in != 2'd0);
         out1_valid = (n_in == 2'd2);
         out0_pc    = cmp0.pc;
         out0_inst  = cmp0.inst;
         out1_pc    = cmp1.pc;
         out1_inst  = cmp1.inst;
         // Decode takes the bypassed slots directly, so nothing is stored.
         byp_take   = dec_ready;
      end
`endif
   end

   assign enq   = in_valid & in_ready & ~flush & ~byp_take;
   assign n_out = dec_ready ? ({1'b0, q_v0} + {1'b0, q_v1}) : 2'd0;

   always_comb begin
      head_d  = head_q + ptr_t'(n_out);
      tail_d  = enq ? (tail_q + ptr_t'(n_in)) : tail_q;
      count_d = count_q + (enq ? cnt_t'(n_in) : cnt_t'(0)) - cnt_t'(n_out);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (enq && (n_in != 2'd0)) mem_q[tail_q] <= cmp0;
      if (enq && (n_in == 2'd2)) mem_q[tail_q + ptr_t'(1)] <= cmp1;
   end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table plus scoreboard of expected entries.
module tb_inst_queue;
   import inst_queue_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic        in_inst0_valid, in_inst1_valid;
   logic [31:0] in_inst0_pc, in_inst1_pc, in_inst0_inst, in_inst1_inst;
   logic        out0_valid, out1_valid;
   logic [31:0] out0_pc, out0_inst, out1_pc, out1_inst;
   logic        dec_ready;

   int total = 0;
   int bad   = 0;
   iq_entry_t sb[$];

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_inst0_valid (in_inst0_valid),
      .in_inst1_valid (in_inst1_valid),
      .in_inst0_pc    (in_inst0_pc),
      .in_inst1_pc    (in_inst1_pc),
      .in_inst0_inst  (in_inst0_inst),
      .in_inst1_inst  (in_inst1_inst),
      .out0_valid     (out0_valid),
      .out1_valid     (out1_valid),
      .out0_pc        (out0_pc),
      .out0_inst      (out0_inst),
      .out1_pc        (out1_pc),
      .out1_inst      (out1_inst),
      .dec_ready      (dec_ready)
   );

   typedef struct {
      logic        iv;
      logic        v0;
      logic [31:0] pc0;
      logic        v1;
      logic [31:0] pc1;
      logic        dr;
      logic        fl;
      int          cnt;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hC0DE_0000;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;
      in_inst0_valid = 1'b0; in_inst1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      #1;
      chk("rst_count", 32'(dut.count_q), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out0_valid", 32'(out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
   endtask

   // One cycle: drive, check presented outputs against the model, update model, check count.
   task automatic step(input logic iv, input logic v0, input logic [31:0] pc0,
                       input logic v1, input logic [31:0] pc1, input logic dr, input logic fl);
      iq_entry_t cin[$];
      iq_entry_t e0, e1;
      int  n;
      logic byp, ev0, ev1, erdy;
      @(negedge clk);
      in_valid = iv; in_inst0_valid = v0; in_inst1_valid = v1;
      in_inst0_pc = pc0; in_inst0_inst = inst_of(pc0);
      in_inst1_pc = pc1; in_inst1_inst = inst_of(pc1);
      dec_ready = dr; flush = fl;
      #1;
      n    = sb.size();
      erdy = ((DEPTH - n) >= 2);
      if (v0) cin.push_back('{pc: pc0, inst: inst_of(pc0)});
      if (v1) cin.push_back('{pc: pc1, inst: inst_of(pc1)});
      byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      byp = (n == 0) && !fl && iv;
`endif
      e0 = '0; e1 = '0;
      if (byp) begin
         ev0 = (cin.size() >= 1);
         ev1 = (cin.size() == 2);
         if (ev0) e0 = cin[0];
         if (ev1) e1 = cin[1];
      end else begin
         ev0 = (n >= 1);
         ev1 = (n >= 2);
         if (ev0) e0 = sb[0];
         if (ev1) e1 = sb[1];
      end
      chk("in_ready", 32'(in_ready), 32'(erdy));
      chk("out0_valid", 32'(out0_valid), 32'(ev0));
      chk("out1_valid", 32'(out1_valid), 32'(ev1));
      if (ev0) begin
         chk("out0_pc", out0_pc, e0.pc);
         chk("out0_inst", out0_inst, e0.inst);
      end
      if (ev1) begin
         chk("out1_pc", out1_pc, e1.pc);
         chk("out1_inst", out1_inst, e1.inst);
      end
      if (fl) begin
         sb.delete();
      end else begin
         if (!byp && dr) begin
            if (n >= 1) void'(sb.pop_front());
            if (n >= 2) void'(sb.pop_front());
         end
         if (iv && erdy && !(byp && dr)) begin
            foreach (cin[i]) sb.push_back(cin[i]);
         end
      end
      @(posedge clk);
      #1;
      chk("count_model", 32'(dut.count_q), 32'(sb.size()));
   endtask

   task automatic idle(input logic dr);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, dr, 1'b0);
   endtask

   task automatic pkt2(input logic [31:0] pc, input logic dr);
      step(1'b1, 1'b1, pc, 1'b1, pc + 32'd4, dr, 1'b0);
   endtask

   initial begin
      logic [31:0] p;
      int byp_cnt;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; dec_ready = 1'b0;
      in_inst0_valid = 1'b0; in_inst1_valid = 1'b0;
      in_inst0_pc = '0; in_inst1_pc = '0; in_inst0_inst = '0; in_inst1_inst = '0;

      vecs[0] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 0};
      vecs[1] = '{1'b1, 1'b0, 32'h1000, 1'b1, 32'h1004, 1'b0, 1'b0, 1};
      vecs[2] = '{1'b1, 1'b1, 32'h1008, 1'b1, 32'h100C, 1'b0, 1'b0, 3};
      vecs[3] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 3};
      vecs[4] = '{1'b1, 1'b1, 32'h1010, 1'b0, 32'h1014, 1'b0, 1'b0, 4};
      vecs[5] = '{1'b1, 1'b0, 32'h1018, 1'b0, 32'h101C, 1'b0, 1'b0, 4};
      vecs[6] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 2};
      vecs[7] = '{1'b1, 1'b1, 32'h1020, 1'b1, 32'h1024, 1'b1, 1'b0, 2};
      vecs[8] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 0};
      vecs[9] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 0};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].iv, vecs[i].v0, vecs[i].pc0, vecs[i].v1, vecs[i].pc1,
              vecs[i].dr, vecs[i].fl);
         chk($sformatf("vec%0d_count", i), 32'(dut.count_q), 32'(vecs[i].cnt));
      end

      // Fill with full packets until full.
      do_reset();
      for (int i = 0; i < 4; i++) pkt2(32'h4000 + 32'(i * 8), 1'b0);
      in_valid = 1'b0;
      chk("full_count", 32'(dut.count_q), 32'd8);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      idle(1'b0);

      // count = DEPTH-1 still refuses a single-slot packet.
      do_reset();
      for (int i = 0; i < 3; i++) pkt2(32'h5000 + 32'(i * 8), 1'b0);
      step(1'b1, 1'b1, 32'h5018, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("cnt7_in_ready", 32'(in_ready), 32'd0);
      step(1'b1, 1'b1, 32'h501C, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("cnt7_hold", 32'(dut.count_q), 32'd7);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // Sustained two-in/two-out across several pointer wraps.
      do_reset();
      p = 32'h3000;
      for (int i = 0; i < 2; i++) begin pkt2(p, 1'b0); p += 32'd8; end
      for (int i = 0; i < 30; i++) begin pkt2(p, 1'b1); p += 32'd8; end
      chk("steady_count", 32'(dut.count_q), 32'd4);
      idle(1'b1);
      idle(1'b1);

      // Flush at count 5 alongside a packet and dec_ready.
      do_reset();
      pkt2(32'h6000, 1'b0);
      pkt2(32'h6008, 1'b0);
      step(1'b1, 1'b1, 32'h6010, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("pre_flush_count", 32'(dut.count_q), 32'd5);
      step(1'b1, 1'b1, 32'h6020, 1'b1, 32'h6024, 1'b1, 1'b1);
      in_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flush_count", 32'(dut.count_q), 32'd0);
      chk("flush_out0_valid", 32'(out0_valid), 32'd0);
      chk("flush_out1_valid", 32'(out1_valid), 32'd0);
      idle(1'b1);

      // Empty queue with dec_ready: bypassed when enabled, else stored.
      do_reset();
`ifdef INST_QUEUE_BYPASS_EN
      byp_cnt = 0;
`else
      byp_cnt = 2;
`endif
      pkt2(32'h2000, 1'b1);
      chk("empty_pkt_count", 32'(dut.count_q), 32'(byp_cnt));
      idle(1'b1);
      idle(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
